// File: rtl/jpeg_bitstream_reader.sv
// JPEG entropy-coded bitstream reader.
// Strips the 0x00 stuffing byte that follows each 0xFF, drops 0xFF fill
// bytes and stalls on markers. Destuffed bits are packed MSB-first into a
// bit buffer and exposed through a peek window with a variable-length
// consume port for a downstream Huffman/VLC decoder.
module jpeg_bitstream_reader #(
  parameter int BUF_W  = 32,
  parameter int PEEK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PEEK_W-1:0] peek_data,
  output logic              peek_valid,
  input  logic              consume_en,
  input  logic [4:0]        consume_len,
  output logic [5:0]        bit_cnt,
  output logic              marker_found,
  output logic [7:0]        marker_code,
  input  logic              marker_ack,
  output logic              err
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    FF_SEEN = 2'd1,
    MARKER  = 2'd2
  } state_t;

  // A byte is only accepted when a full byte still fits after the worst case
  // of no consume in the same cycle.
  localparam logic [5:0] FILL_LIMIT = 6'(BUF_W - 8);
  localparam logic [5:0] PEEK_LEN   = 6'(PEEK_W);

  state_t             state;
  logic [BUF_W-1:0]   buffer;
  logic               run;

  logic               in_marker;
  logic               accept;
  logic [5:0]         len_ext;
  logic               consume_ok;
  logic               consume_bad;
  logic [BUF_W-1:0]   shifted;
  logic [5:0]         cnt_after;
  logic               append_en;
  logic [7:0]         append_byte;
  logic [BUF_W-1:0]   appended;
  logic [BUF_W-1:0]   valid_mask;
  logic [BUF_W-1:0]   padded;

  // Handshake and peek outputs derived purely from registered state; run
  // keeps in_ready low while reset is held and for the first edge after it.
  always_comb begin
    in_marker  = (state == MARKER);
    in_ready   = run && !in_marker && (bit_cnt <= FILL_LIMIT);
    accept     = in_valid && in_ready;
    peek_valid = (bit_cnt >= PEEK_LEN) || in_marker;
    valid_mask = ~({BUF_W{1'b1}} >> bit_cnt);
    padded     = (buffer & valid_mask) | ~valid_mask;
    peek_data  = peek_valid ? padded[BUF_W-1 -: PEEK_W] : '0;
  end

  // Consume legality and the post-consume buffer; inside a marker an
  // over-long consume simply empties the buffer.
  always_comb begin
    len_ext     = {1'b0, consume_len};
    consume_ok  = consume_en &&
                  (in_marker || ((len_ext <= PEEK_LEN) && (len_ext <= bit_cnt)));
    consume_bad = consume_en && !consume_ok;
    shifted     = buffer;
    cnt_after   = bit_cnt;
    if (consume_ok) begin
      shifted = buffer << consume_len;
      if (len_ext >= bit_cnt) begin
        cnt_after = 6'd0;
      end else begin
        cnt_after = bit_cnt - len_ext;
      end
    end
  end

  // Destuffing decode: decide whether the accepted byte contributes data
  // bits, and place them right after whatever survives the consume.
  always_comb begin
    append_en   = 1'b0;
    append_byte = 8'h00;
    if (accept) begin
      if (state == NORMAL && in_data != 8'hFF) begin
        append_en   = 1'b1;
        append_byte = in_data;
      end else if (state == FF_SEEN && in_data == 8'h00) begin
        append_en   = 1'b1;
        append_byte = 8'hFF;
      end
    end
    appended = shifted | ({append_byte, {(BUF_W-8){1'b0}}} >> cnt_after);
  end

  // Main state machine: buffer, bit count, marker capture and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= NORMAL;
      buffer       <= '0;
      bit_cnt      <= 6'd0;
      marker_found <= 1'b0;
      marker_code  <= 8'h00;
      err          <= 1'b0;
      run          <= 1'b0;
    end else begin
      run <= 1'b1;
      if (sync_clr) begin
        state        <= NORMAL;
        buffer       <= '0;
        bit_cnt      <= 6'd0;
        marker_found <= 1'b0;
        marker_code  <= 8'h00;
        err          <= 1'b0;
      end else if (in_marker && marker_ack) begin
        state        <= NORMAL;
        buffer       <= '0;
        bit_cnt      <= 6'd0;
        marker_found <= 1'b0;
      end else begin
        if (consume_bad) begin
          err <= 1'b1;
        end
        buffer  <= append_en ? appended : shifted;
        bit_cnt <= append_en ? (cnt_after + 6'd8) : cnt_after;
        if (accept) begin
          case (state)
            NORMAL: begin
              if (in_data == 8'hFF) begin
                state <= FF_SEEN;
              end
            end
            FF_SEEN: begin
              if (in_data == 8'h00) begin
                state <= NORMAL;
              end else if (in_data != 8'hFF) begin
                marker_code  <= in_data;
                marker_found <= 1'b1;
                state        <= MARKER;
              end
            end
            default: begin
              state <= state;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_reader.sv
// Testbench for jpeg_bitstream_reader: directed scenarios plus randomized
// traffic against a bit-queue reference model, checked via a scoreboard.
module tb_jpeg_bitstream_reader;

  logic        clk;
  logic        rst_n;
  logic        sync_clr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] peek_data;
  logic        peek_valid;
  logic        consume_en;
  logic [4:0]  consume_len;
  logic [5:0]  bit_cnt;
  logic        marker_found;
  logic [7:0]  marker_code;
  logic        marker_ack;
  logic        err;

  jpeg_bitstream_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_clr     (sync_clr),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .peek_data    (peek_data),
    .peek_valid   (peek_valid),
    .consume_en   (consume_en),
    .consume_len  (consume_len),
    .bit_cnt      (bit_cnt),
    .marker_found (marker_found),
    .marker_code  (marker_code),
    .marker_ack   (marker_ack),
    .err          (err)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    logic [15:0] peek;
    bit         pv;
    bit         rdy;
    bit         mf;
    logic [7:0] code;
    bit         er;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: destuffed bits as a plain FIFO of bits.
  bit         mq[$];
  bit         m_ff;
  bit         m_marker;
  bit         m_err;
  bit         m_run;
  logic [7:0] m_code;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt  = mq.size();
    e.pv   = (mq.size() >= 16) || m_marker;
    e.peek = 16'h0;
    if (e.pv) begin
      for (int i = 0; i < 16; i++) begin
        e.peek[15-i] = (i < mq.size()) ? mq[i] : 1'b1;
      end
    end
    e.rdy  = m_run && !m_marker && (mq.size() <= 24);
    e.mf   = m_marker;
    e.code = m_code;
    e.er   = m_err;
    return e;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_ff = 0; m_marker = 0; m_err = 0; m_run = 0; m_code = 8'h00;
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge,
  // then post the expected post-edge outputs to the scoreboard.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit cen,
                               input logic [4:0] clen, input bit ack, input bit clr,
                               output bit acc);
    bit rdy;
    int n;
    in_valid = v; in_data = d; consume_en = cen; consume_len = clen;
    marker_ack = ack; sync_clr = clr;
    rdy = m_run && !m_marker && (mq.size() <= 24);
    acc = v && rdy;
    if (clr) begin
      mq.delete();
      m_ff = 0; m_marker = 0; m_err = 0; m_code = 8'h00;
    end else if (m_marker && ack) begin
      mq.delete();
      m_marker = 0;
    end else begin
      if (cen) begin
        if (m_marker) begin
          n = (int'(clen) > mq.size()) ? mq.size() : int'(clen);
          repeat (n) void'(mq.pop_front());
        end else if (clen <= 16 && int'(clen) <= mq.size()) begin
          repeat (int'(clen)) void'(mq.pop_front());
        end else begin
          m_err = 1;
        end
      end
      if (acc) begin
        if (!m_ff) begin
          if (d == 8'hFF) m_ff = 1;
          else for (int b = 7; b >= 0; b--) mq.push_back(d[b]);
        end else if (d == 8'h00) begin
          for (int b = 0; b < 8; b++) mq.push_back(1'b1);
          m_ff = 0;
        end else if (d != 8'hFF) begin
          m_code = d; m_marker = 1; m_ff = 0;
        end
      end
    end
    m_run = 1;
    @(posedge clk);
    #1;
    exp_q.push_back(snapshot());
  endtask

  task automatic idle();
    bit acc;
    applyStimulus(0, 8'h00, 0, 5'd0, 0, 0, acc);
  endtask

  task automatic clearAll();
    bit acc;
    applyStimulus(0, 8'h00, 0, 5'd0, 0, 1, acc);
  endtask

  task automatic sendByte(input logic [7:0] d);
    bit acc;
    applyStimulus(1, d, 0, 5'd0, 0, 0, acc);
    checkOutput("byte_accepted", {31'd0, acc}, 32'd1);
  endtask

  // Scoreboard monitor: pops one expectation per posted cycle on the
  // falling edge and compares every output field.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_bit_cnt",      {26'd0, bit_cnt},      e.cnt);
        checkOutput("sb_peek_valid",   {31'd0, peek_valid},   {31'd0, e.pv});
        checkOutput("sb_peek_data",    {16'd0, peek_data},    {16'd0, e.peek});
        checkOutput("sb_in_ready",     {31'd0, in_ready},     {31'd0, e.rdy});
        checkOutput("sb_marker_found", {31'd0, marker_found}, {31'd0, e.mf});
        checkOutput("sb_marker_code",  {24'd0, marker_code},  {24'd0, e.code});
        checkOutput("sb_err",          {31'd0, err},          {31'd0, e.er});
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    bit         acc;
    logic [7:0] cur;
    int         r;
    int         mx;
    bit         cen;
    logic [4:0] clen;
    int         waits;

    rst_n = 1'b0; sync_clr = 0; in_data = 0; in_valid = 0;
    consume_en = 0; consume_len = 0; marker_ack = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_bit_cnt",  {26'd0, bit_cnt},   32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready},  32'd0);
    checkOutput("rst_peek",     {16'd0, peek_data}, 32'd0);
    checkOutput("rst_err",      {31'd0, err},       32'd0);
    rst_n = 1'b1;
    idle();
    checkOutput("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Plain packing and a 4-bit consume.
    sendByte(8'hA5); sendByte(8'h3C); sendByte(8'hC3);
    checkOutput("t1_cnt",  {26'd0, bit_cnt},   32'd24);
    checkOutput("t1_peek", {16'd0, peek_data}, 32'hA53C);
    checkOutput("t1_pv",   {31'd0, peek_valid}, 32'd1);
    applyStimulus(0, 8'h00, 1, 5'd4, 0, 0, acc);
    checkOutput("t1_peek_c4", {16'd0, peek_data}, 32'h53CC);
    checkOutput("t1_cnt_c4",  {26'd0, bit_cnt},   32'd20);

    // Stuffed 0x00 after 0xFF is removed.
    clearAll();
    sendByte(8'h12); sendByte(8'hFF); sendByte(8'h00); sendByte(8'h34);
    checkOutput("t2_cnt",  {26'd0, bit_cnt},   32'd24);
    checkOutput("t2_peek", {16'd0, peek_data}, 32'h12FF);

    // Fill bytes then a marker.
    clearAll();
    sendByte(8'hAB); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'hD9);
    checkOutput("t3_mf",    {31'd0, marker_found}, 32'd1);
    checkOutput("t3_code",  {24'd0, marker_code},  32'hD9);
    checkOutput("t3_ready", {31'd0, in_ready},     32'd0);
    checkOutput("t3_cnt",   {26'd0, bit_cnt},      32'd8);
    checkOutput("t3_peek",  {16'd0, peek_data},    32'hABFF);
    applyStimulus(0, 8'h00, 1, 5'd3, 1, 0, acc);
    checkOutput("t3_ack_cnt",   {26'd0, bit_cnt},  32'd0);
    checkOutput("t3_ack_ready", {31'd0, in_ready}, 32'd1);

    // Streaming: one append and one 8-bit consume per cycle.
    clearAll();
    sendByte(8'h00); sendByte(8'h11);
    for (int k = 2; k <= 14; k++) begin
      applyStimulus(1, 8'(k * 17), 1, 5'd8, 0, 0, acc);
      checkOutput("t4_acc",   {31'd0, acc},       32'd1);
      checkOutput("t4_cnt",   {26'd0, bit_cnt},   32'd16);
      checkOutput("t4_ready", {31'd0, in_ready},  32'd1);
      checkOutput("t4_peek",  {16'd0, peek_data}, {16'd0, 8'((k - 1) * 17), 8'(k * 17)});
    end

    // Illegal consume length sets the sticky error.
    clearAll();
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03);
    applyStimulus(0, 8'h00, 1, 5'd17, 0, 0, acc);
    checkOutput("t5_err", {31'd0, err},     32'd1);
    checkOutput("t5_cnt", {26'd0, bit_cnt}, 32'd24);
    clearAll();
    checkOutput("t5_clr_err", {31'd0, err},     32'd0);
    checkOutput("t5_clr_cnt", {26'd0, bit_cnt}, 32'd0);

    // Full buffer, then asynchronous reset mid-stream.
    sendByte(8'h10); sendByte(8'h20); sendByte(8'h30); sendByte(8'h40);
    checkOutput("t6_cnt32",  {26'd0, bit_cnt},  32'd32);
    checkOutput("t6_ready0", {31'd0, in_ready}, 32'd0);
    #6;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_rst_cnt",   {26'd0, bit_cnt},      32'd0);
    checkOutput("t6_rst_ready", {31'd0, in_ready},     32'd0);
    checkOutput("t6_rst_peek",  {16'd0, peek_data},    32'd0);
    checkOutput("t6_rst_pv",    {31'd0, peek_valid},   32'd0);
    checkOutput("t6_rst_mf",    {31'd0, marker_found}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    checkOutput("t6_rel_ready", {31'd0, in_ready}, 32'd1);
    sendByte(8'h7E);
    checkOutput("t6_cnt8", {26'd0, bit_cnt}, 32'd8);

    // Randomized traffic against the model.
    clearAll();
    cur = 8'h55;
    for (int i = 0; i < 1500; i++) begin
      cen = ($urandom_range(0, 1) == 1);
      if (m_marker) begin
        clen = 5'($urandom_range(0, 20));
      end else begin
        mx = (mq.size() < 16) ? mq.size() : 16;
        clen = 5'($urandom_range(0, mx));
      end
      applyStimulus($urandom_range(0, 3) != 0, cur, cen, clen,
                    m_marker ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0),
                    0, acc);
      if (acc) begin
        r = $urandom_range(0, 99);
        if (r < 15)      cur = 8'hFF;
        else if (r < 27) cur = 8'h00;
        else             cur = 8'($urandom_range(0, 255));
      end
    end

    // Let the scoreboard drain, bounded.
    in_valid = 0; consume_en = 0; marker_ack = 0; sync_clr = 0;
    waits = 0;
    while (exp_q.size() > 0 && waits < 10) begin
      @(posedge clk);
      waits++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_bitstream_reader.md
Name: jpeg_bitstream_reader

Overview:
- Receive-side counterpart of the jpeg_encoder bitstream packer.
- Accepts the byte-stuffed JPEG entropy-coded byte stream and removes the 0x00 stuffing byte after each 0xFF.
- Skips 0xFF fill bytes and stops on markers (0xFF followed by a byte other than 0x00 or 0xFF).
- Presents an MSB-first 16-bit peek window with a variable-length consume port for a downstream Huffman/VLC decoder.

Parameters:
- BUF_W, 32, bit-buffer width; fixed at 32 (other values not supported).
- PEEK_W, 16, peek window width and maximum consume length.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sync_clr  in  1  synchronous clear: empties the buffer and returns to NORMAL.
- in_data  in  8  stuffed stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- peek_data  out  16  next 16 unconsumed bits, MSB = oldest bit.
- peek_valid  out  1  peek_data is meaningful.
- consume_en  in  1  consume consume_len bits this cycle.
- consume_len  in  5  bit count, 0..16.
- bit_cnt  out  6  valid bits buffered, 0..32.
- marker_found  out  1  marker detected; input is stalled.
- marker_code  out  8  second byte of the marker.
- marker_ack  in  1  release the marker and discard buffered bits.
- err  out  1  sticky: illegal consume.

Behaviour:
- Reset (rst_n low, async) and sync_clr:
  - buffer = 0, bit_cnt = 0, state = NORMAL.
  - marker_found = 0, marker_code = 0x00, err = 0, peek_data = 0, peek_valid = 0.
  - in_ready = 0 while rst_n is low.
- in_ready = (state != MARKER) && (bit_cnt <= 24). Combinational from registers only; no input-to-output combinational path.
- States:
  - NORMAL, byte != 0xFF: append 8 bits.
  - NORMAL, byte == 0xFF: append nothing; go to FF_SEEN.
  - FF_SEEN, byte 0x00: append 0xFF; go to NORMAL.
  - FF_SEEN, byte 0xFF: fill byte, append nothing; stay in FF_SEEN.
  - FF_SEEN, any other byte: marker_code <= byte, marker_found <= 1; go to MARKER.
  - MARKER: in_ready = 0. On marker_ack: bit_cnt <= 0, marker_found <= 0; go to NORMAL. marker_ack outside MARKER is ignored.
- Latency: a byte accepted in cycle N is visible in peek_data and bit_cnt in cycle N+1.
- peek_valid = (bit_cnt >= 16) || (state == MARKER).
- peek_data = the top 16 valid bits. Bit positions at or beyond bit_cnt read as 1 (JPEG pad convention).
- Consume:
  - Legal when consume_len <= 16 and consume_len <= bit_cnt, or when in MARKER.
  - In MARKER, consuming more than bit_cnt saturates bit_cnt to 0.
  - Illegal consume: no state change, err <= 1 (sticky until reset or sync_clr).
  - consume_len = 0 is a legal no-op.
- Simultaneous consume and append in one cycle:
  - bit_cnt_next = bit_cnt - consume_len + 8.
  - The consume shift is applied first; appended bits land directly after the remaining bits.
  - The bit_cnt <= 24 gate guarantees no overflow.
- Simultaneous marker_ack and consume: marker_ack wins; buffer is cleared.
- Reset mid-marker: all state returns to reset values.
- Bit order: in_data[7] is the oldest bit of its byte.

Test Plan:
- Reset, then bytes A5 3C C3 -> after 3rd byte accepted: bit_cnt = 24, peek_data = 0xA53C, peek_valid = 1; consume 4 -> peek_data = 0x53CC, bit_cnt = 20.
- Bytes 12 FF 00 34 -> bit_cnt = 24, peek_data = 0x12FF; the stuffed 0x00 never appears.
- Bytes AB FF FF FF D9 -> marker_found = 1, marker_code = 0xD9, in_ready = 0, bit_cnt = 8, peek_data = 0xABFF (pad 1s); marker_ack -> bit_cnt = 0, in_ready = 1.
- Hold consume of 8 each cycle with continuous input 00 11 22 33 ... -> once bit_cnt first reaches 16, it holds at 16 and in_ready stays 1 (one append + one consume per cycle); bytes emerge in order with no loss.
- Buffer at 24 bits, consume_len = 17 -> err = 1, bit_cnt stays 24; sync_clr -> err = 0, bit_cnt = 0.
- Fill to 32 bits (in_ready = 0), assert rst_n low mid-stream -> all outputs immediately 0; after release, in_ready = 1 and the next byte 0x7E gives bit_cnt = 8.
